// File: rtl/vector_lane_engine_if.sv
// ---------------------------------------------------------------------------
// vector_lane_engine_if
//
// Bundle between vector issue (operand read) and the vector_lane_engine.
// The issue side drives the instruction and its operands; the engine
// returns the finished destination value and its status.
//
// Signals:
//   rdy_in          global enable; low freezes the engine
//   in_valid        instruction offered
//   in_ready        engine can accept this cycle
//   vsew            element width code (0=8,1=16,2=32,3=64 bits)
//   vl              requested element count
//   vm              1 = unmasked, 0 = use mask
//   op              operation code
//   opnd_sel        0 = vector-vector (vs1), 1 = vector-scalar (rs)
//   vs1, vs2        vector operands
//   vd_old          previous destination value
//   mask            mask register
//   rs              scalar operand
//   result          destination value
//   result_is_mask  result uses the one-bit-per-element mask layout
//   result_valid    result complete
//   busy            engine is sequencing elements
//   illegal         one-cycle pulse when an illegal instruction is taken
// ---------------------------------------------------------------------------
interface vector_lane_engine_if #(
    parameter int VLEN     = 256,
    parameter int VL_WIDTH = 9
);
    logic                rdy_in;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          vsew;
    logic [VL_WIDTH-1:0] vl;
    logic                vm;
    logic [3:0]          op;
    logic                opnd_sel;
    logic [VLEN-1:0]     vs1;
    logic [VLEN-1:0]     vs2;
    logic [VLEN-1:0]     vd_old;
    logic [VLEN-1:0]     mask;
    logic [63:0]         rs;
    logic [VLEN-1:0]     result;
    logic                result_is_mask;
    logic                result_valid;
    logic                busy;
    logic                illegal;

    modport master (
        output rdy_in, in_valid, vsew, vl, vm, op, opnd_sel,
               vs1, vs2, vd_old, mask, rs,
        input  in_ready, result, result_is_mask, result_valid, busy, illegal
    );

    modport slave (
        input  rdy_in, in_valid, vsew, vl, vm, op, opnd_sel,
               vs1, vs2, vd_old, mask, rs,
        output in_ready, result, result_is_mask, result_valid, busy, illegal
    );
endinterface

// File: rtl/vector_lane_engine.sv
// ---------------------------------------------------------------------------
// vector_lane_engine
//
// Executes one vector integer instruction at a time. It walks vl elements
// through LANE_SIZE parallel lanes, LANE_SIZE elements per cycle, at a
// runtime element width (SEW) of 8/16/32/64 bits. Masked-off and tail
// elements keep their old destination value. Compare ops write one bit
// per element.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   vector_lane_engine_if.slave (instruction in, result out)
//
// Parameters:
//   VLEN       vector register width in bits
//   LANE_SIZE  elements per cycle (power of two, <= VLEN/64)
//   VL_WIDTH   width of vl (2**VL_WIDTH > VLEN/8)
// ---------------------------------------------------------------------------
module vector_lane_engine #(
    parameter int VLEN      = 256,
    parameter int LANE_SIZE = 4,
    parameter int VL_WIDTH  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_lane_engine_if.slave  bus
);
    // idx can run one group past vl_eff, so it gets a spare bit.
    localparam int IDX_W = VL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Latched instruction (control)
    logic [IDX_W-1:0]    idx;
    logic [1:0]          sew_q;
    logic [VL_WIDTH-1:0] vl_eff_q;
    logic                vm_q;
    logic [3:0]          op_q;
    logic                sel_q;
    logic                result_is_mask_q;
    logic                illegal_q;

    // Latched operands (data)
    logic [VLEN-1:0]     vs1_q;
    logic [VLEN-1:0]     vs2_q;
    logic [VLEN-1:0]     mask_q;
    logic [63:0]         rs_q;

    logic [VLEN-1:0]     result_q;
    logic [VLEN-1:0]     run_result;

    logic                in_ready;
    logic                accept;
    logic                bad_in;
    logic                start_empty;
    logic                last_group;
    logic                busy;
    logic                result_valid;
    logic [VL_WIDTH-1:0] vlmax_in;
    logic [VL_WIDTH-1:0] vl_eff_in;

    // -----------------------------------------------------------------------
    // Element helpers
    // -----------------------------------------------------------------------
    function automatic logic [63:0] sew_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic signed [63:0] sign_ext(input logic [63:0] x,
                                                    input logic [1:0]  s);
        case (s)
            2'd0:    return {{56{x[7]}},  x[7:0]};
            2'd1:    return {{48{x[15]}}, x[15:0]};
            2'd2:    return {{32{x[31]}}, x[31:0]};
            default: return x;
        endcase
    endfunction

    // Arithmetic/logic ops. Operands arrive zero-extended (au/bu) and
    // sign-extended (a_s/b_s) from SEW; the caller truncates back to SEW,
    // which gives modulo-2^SEW wrap for ADD/SUB.
    function automatic logic [63:0] elem_op(input logic [3:0]         o,
                                            input logic [63:0]        au,
                                            input logic [63:0]        bu,
                                            input logic signed [63:0] a_s,
                                            input logic signed [63:0] b_s);
        case (o)
            4'd0:    return au + bu;
            4'd1:    return au - bu;
            4'd2:    return au & bu;
            4'd3:    return au | bu;
            4'd4:    return au ^ bu;
            4'd5:    return (au < bu)   ? au : bu;
            4'd6:    return (a_s < b_s) ? au : bu;
            4'd7:    return (au > bu)   ? au : bu;
            4'd8:    return (a_s > b_s) ? au : bu;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic elem_cmp(input logic [3:0]         o,
                                      input logic [63:0]        au,
                                      input logic [63:0]        bu,
                                      input logic signed [63:0] a_s,
                                      input logic signed [63:0] b_s);
        case (o)
            4'd9:    return au == bu;
            4'd10:   return au != bu;
            4'd11:   return au < bu;
            4'd12:   return a_s < b_s;
            default: return 1'b0;
        endcase
    endfunction

    // Applies element e to the running destination value. Element
    // positions are computed as shifts so one lane serves every SEW.
    function automatic logic [VLEN-1:0] lane_update(input logic [VLEN-1:0] acc,
                                                    input int              e);
        logic [63:0]        m;
        logic [63:0]        au;
        logic [63:0]        bu;
        logic signed [63:0] a_s;
        logic signed [63:0] b_s;
        logic [VLEN-1:0]    msel;
        logic               active;
        int                 sh;
        sh     = e << (32'(sew_q) + 3);
        m      = sew_mask(sew_q);
        au     = 64'(vs2_q >> sh) & m;
        bu     = (sel_q ? rs_q : 64'(vs1_q >> sh)) & m;
        a_s    = sign_ext(au, sew_q);
        b_s    = sign_ext(bu, sew_q);
        msel   = mask_q >> e;
        active = (e < int'(vl_eff_q)) && (vm_q || msel[0]);
        lane_update = acc;
        if (active) begin
            if (op_q >= 4'd9) begin
                lane_update = (acc & ~(VLEN'(1) << e))
                            | (VLEN'(elem_cmp(op_q, au, bu, a_s, b_s)) << e);
            end else begin
                lane_update = (acc & ~(VLEN'(m) << sh))
                            | (VLEN'(elem_op(op_q, au, bu, a_s, b_s) & m) << sh);
            end
        end
    endfunction

    // -----------------------------------------------------------------------
    // Acceptance decode
    // -----------------------------------------------------------------------
    assign in_ready    = bus.rdy_in && (state == IDLE || state == DONE);
    assign accept      = bus.in_valid && in_ready;
    assign bad_in      = bus.vsew[2] || (bus.op > 4'd12);
    assign vlmax_in    = VL_WIDTH'(VLEN / 8) >> bus.vsew[1:0];
    assign vl_eff_in   = (bus.vl < vlmax_in) ? bus.vl : vlmax_in;
    // Nothing to compute: finish in one cycle with result = vd_old.
    assign start_empty = bad_in || (vl_eff_in == '0);
    assign last_group  = (idx + IDX_W'(LANE_SIZE)) >= IDX_W'(vl_eff_q);

    // -----------------------------------------------------------------------
    // Lane datapath: one group of LANE_SIZE elements per RUN cycle
    // -----------------------------------------------------------------------
    always_comb begin
        run_result = result_q;
        for (int j = 0; j < LANE_SIZE; j++) begin
            run_result = lane_update(run_result, int'(idx) + j);
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = start_empty ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (bus.rdy_in && last_group) state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (accept) begin
                    state_nxt = start_empty ? DONE : RUN;
                end else if (bus.rdy_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control state and destination register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx              <= '0;
            sew_q            <= '0;
            vl_eff_q         <= '0;
            vm_q             <= 1'b0;
            op_q             <= '0;
            sel_q            <= 1'b0;
            result_is_mask_q <= 1'b0;
            illegal_q        <= 1'b0;
            result_q         <= '0;
        end else if (bus.rdy_in) begin
            illegal_q <= accept && bad_in;
            if (accept) begin
                idx              <= '0;
                sew_q            <= bus.vsew[1:0];
                vl_eff_q         <= bad_in ? '0 : vl_eff_in;
                vm_q             <= bus.vm;
                op_q             <= bus.op;
                sel_q            <= bus.opnd_sel;
                result_is_mask_q <= !bad_in && (bus.op >= 4'd9);
                result_q         <= bus.vd_old;
            end else if (state == RUN) begin
                idx      <= idx + IDX_W'(LANE_SIZE);
                result_q <= run_result;
            end
        end
    end

    // Operand capture; only meaningful after an acceptance, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            vs1_q  <= bus.vs1;
            vs2_q  <= bus.vs2;
            mask_q <= bus.mask;
            rs_q   <= bus.rs;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.result         = result_q;
    assign bus.result_is_mask = result_is_mask_q;
    assign bus.result_valid   = result_valid;
    assign bus.busy           = busy;
    assign bus.illegal        = illegal_q;

endmodule
